// File: rtl/led_share_arb.sv
// led_share_arb
//   Round-robin arbiter that shares the 8-LED bank among four pattern
//   sources. An owner keeps the LEDs for at least DWELL_CYCLES cycles while
//   another source is waiting. A single blank (zero-grant) cycle separates
//   consecutive owners.
//
// Ports
//   clk50    in   1   clock, all logic on the rising edge
//   rst      in   1   synchronous, active-high reset
//   req      in   4   level request per source (bit i = source i)
//   pattern  in  32   source data, source i drives [8i+7:8i]
//   grant    out  4   registered one-hot grant, zero when there is no owner
//   LEDS     out  8   registered LED drive, one cycle behind grant
//
// Optional feature
//   LED_ARB_HEARTBEAT_EN: when defined, the LEDs blink bit 7 with a period of
//   2*DWELL_CYCLES zero-grant cycles while nobody owns the bank. When it is
//   undefined, the idle LED value is 8'h00 and no heartbeat logic exists.
module led_share_arb #(
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned TW           = 25
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] pattern,
  output logic [3:0]  grant,
  output logic [7:0]  LEDS
);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(DWELL_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    last_r, last_nxt_s;
  logic [TW-1:0] timer_r, timer_nxt_s, timer_dec_s;
  logic [3:0]    grant_r, grant_nxt_s;
  logic [7:0]    leds_r, leds_nxt_s, idle_leds_s;

  logic [1:0]    start_s, pos_s, win_s;
  logic [7:0]    req_dbl_s;
  logic [3:0]    rot_s, win_onehot_s;
  logic          any_req_s, owner_req_s, other_req_s;

  // Round-robin winner: rotate req so that index last+1 lands at bit 0, then
  // take the first set bit and rotate the position back.
  always_comb begin
    start_s   = last_r + 2'd1;
    req_dbl_s = {req, req};
    rot_s     = req_dbl_s[start_s +: 4];
    casez (rot_s)
      4'b???1: pos_s = 2'd0;
      4'b??10: pos_s = 2'd1;
      4'b?100: pos_s = 2'd2;
      4'b1000: pos_s = 2'd3;
      default: pos_s = 2'd0;
    endcase
    win_s        = start_s + pos_s;
    win_onehot_s = 4'b0001 << win_s;
    any_req_s    = |req;
    // While in GRANT, grant_r is the owner's one-hot mask.
    owner_req_s  = |(req & grant_r);
    other_req_s  = |(req & ~grant_r);
    timer_dec_s  = (timer_r == {TW{1'b0}}) ? timer_r : (timer_r - TW'(1));
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    timer_nxt_s = timer_r;
    grant_nxt_s = grant_r;
    case (state_r)
      ST_IDLE, ST_SWITCH: begin
        if (any_req_s) begin
          state_nxt_s = ST_GRANT;
          grant_nxt_s = win_onehot_s;
          last_nxt_s  = win_s;
          timer_nxt_s = TIMER_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          // A dropped request always ends ownership, even before the dwell.
          state_nxt_s = ST_SWITCH;
          grant_nxt_s = 4'b0000;
          timer_nxt_s = timer_dec_s;
        end else if ((timer_r == {TW{1'b0}}) && other_req_s) begin
          state_nxt_s = ST_SWITCH;
          grant_nxt_s = 4'b0000;
        end else if (timer_r == {TW{1'b0}}) begin
          // Sole requester: keep the LEDs and start a fresh dwell.
          timer_nxt_s = TIMER_LOAD;
        end else begin
          timer_nxt_s = timer_dec_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = 4'b0000;
      end
    endcase
  end

`ifdef LED_ARB_HEARTBEAT_EN
  logic [TW-1:0] hb_cnt_r;
  logic          hb_bit_r;

  // Heartbeat divider: runs only while nobody owns the LEDs, holds otherwise.
  always_ff @(posedge clk50) begin
    if (rst) begin
      hb_cnt_r <= {TW{1'b0}};
      hb_bit_r <= 1'b0;
    end else if (grant_r == 4'b0000) begin
      if (hb_cnt_r == TIMER_LOAD) begin
        hb_cnt_r <= {TW{1'b0}};
        hb_bit_r <= ~hb_bit_r;
      end else begin
        hb_cnt_r <= hb_cnt_r + TW'(1);
      end
    end
  end

  assign idle_leds_s = {hb_bit_r, 7'b000_0000};
`else
  assign idle_leds_s = 8'h00;
`endif

  // LED source select from the registered grant; pattern is not latched.
  always_comb begin
    leds_nxt_s = idle_leds_s;
    case (grant_r)
      4'b0001: leds_nxt_s = pattern[7:0];
      4'b0010: leds_nxt_s = pattern[15:8];
      4'b0100: leds_nxt_s = pattern[23:16];
      4'b1000: leds_nxt_s = pattern[31:24];
      default: leds_nxt_s = idle_leds_s;
    endcase
  end

  // State, pointer, timer and output registers.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_r <= ST_IDLE;
      last_r  <= 2'd3;
      timer_r <= {TW{1'b0}};
      grant_r <= 4'b0000;
      leds_r  <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      timer_r <= timer_nxt_s;
      grant_r <= grant_nxt_s;
      leds_r  <= leds_nxt_s;
    end
  end

  assign grant = grant_r;
  assign LEDS  = leds_r;

endmodule

// File: tb/tb_led_share_arb.sv
module tb_led_share_arb;

  localparam int DW = 8;
  localparam logic [31:0] P  = 32'h3CC3_5AA5;
  localparam logic [31:0] P2 = 32'h3CC3_5A77;

  logic        clk50;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [3:0]  grant;
  logic [7:0]  LEDS;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] pat;
    int          n;
    logic [3:0]  g;
    logic [7:0]  l;
  } vec_t;

  vec_t vecs[$];

  led_share_arb #(.DWELL_CYCLES(DW), .TW(4)) dut (
    .clk50   (clk50),
    .rst     (rst),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .LEDS    (LEDS)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic add(input logic r, input logic [3:0] q, input logic [31:0] p,
                     input int n, input logic [3:0] g, input logic [7:0] l);
    vec_t v;
    v.rst = r; v.req = q; v.pat = p; v.n = n; v.g = g; v.l = l;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int row, input int cyc,
                     input logic [3:0] eg, input logic [7:0] el);
    n_cmp++;
    if (grant !== eg) begin
      n_bad++;
      $display("FAIL %s grant row %0d cyc %0d: got %b want %b", name, row, cyc, grant, eg);
    end
    n_cmp++;
    if (LEDS !== el) begin
      n_bad++;
      $display("FAIL %s LEDS row %0d cyc %0d: got %h want %h", name, row, cyc, LEDS, el);
    end
  endtask

  initial begin
    logic [7:0] hb_exp;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req = 4'b0000;
    pattern = P;

    // reset state
    add(1'b1, 4'b0000, P, 2, 4'b0000, 8'h00);
    // single requester, hold with reload, pattern change passes through
    add(1'b0, 4'b0001, P, 1, 4'b0001, 8'h00);
    add(1'b0, 4'b0001, P, 20, 4'b0001, 8'hA5);
    add(1'b0, 4'b0001, P2, 2, 4'b0001, 8'h77);
    add(1'b0, 4'b0001, P, 1, 4'b0001, 8'hA5);
    // all four requesting for 40 cycles
    add(1'b1, 4'b0000, P, 1, 4'b0000, 8'h00);
    add(1'b0, 4'b1111, P, 1, 4'b0001, 8'h00);
    add(1'b0, 4'b1111, P, 7, 4'b0001, 8'hA5);
    add(1'b0, 4'b1111, P, 1, 4'b0000, 8'hA5);
    add(1'b0, 4'b1111, P, 1, 4'b0010, 8'h00);
    add(1'b0, 4'b1111, P, 7, 4'b0010, 8'h5A);
    add(1'b0, 4'b1111, P, 1, 4'b0000, 8'h5A);
    add(1'b0, 4'b1111, P, 1, 4'b0100, 8'h00);
    add(1'b0, 4'b1111, P, 7, 4'b0100, 8'hC3);
    add(1'b0, 4'b1111, P, 1, 4'b0000, 8'hC3);
    add(1'b0, 4'b1111, P, 1, 4'b1000, 8'h00);
    add(1'b0, 4'b1111, P, 7, 4'b1000, 8'h3C);
    add(1'b0, 4'b1111, P, 1, 4'b0000, 8'h3C);
    add(1'b0, 4'b1111, P, 1, 4'b0001, 8'h00);
    add(1'b0, 4'b1111, P, 3, 4'b0001, 8'hA5);
    // reset in the middle of source 1's ownership
    add(1'b1, 4'b0000, P, 1, 4'b0000, 8'h00);
    add(1'b0, 4'b1111, P, 1, 4'b0001, 8'h00);
    add(1'b0, 4'b1111, P, 7, 4'b0001, 8'hA5);
    add(1'b0, 4'b1111, P, 1, 4'b0000, 8'hA5);
    add(1'b0, 4'b1111, P, 1, 4'b0010, 8'h00);
    add(1'b0, 4'b1111, P, 3, 4'b0010, 8'h5A);
    add(1'b1, 4'b1111, P, 1, 4'b0000, 8'h00);
    add(1'b0, 4'b1111, P, 1, 4'b0001, 8'h00);
    add(1'b0, 4'b1111, P, 2, 4'b0001, 8'hA5);
    // source 2 drops early while source 0 waits
    add(1'b1, 4'b0000, P, 1, 4'b0000, 8'h00);
    add(1'b0, 4'b0100, P, 1, 4'b0100, 8'h00);
    add(1'b0, 4'b0101, P, 2, 4'b0100, 8'hC3);
    add(1'b0, 4'b0001, P, 1, 4'b0000, 8'hC3);
    add(1'b0, 4'b0001, P, 1, 4'b0001, 8'h00);
    add(1'b0, 4'b0001, P, 2, 4'b0001, 8'hA5);
    // pointer wrap: source 3 owns (one reload), then 1001 at expiry
    add(1'b1, 4'b0000, P, 1, 4'b0000, 8'h00);
    add(1'b0, 4'b1000, P, 1, 4'b1000, 8'h00);
    add(1'b0, 4'b1000, P, 15, 4'b1000, 8'h3C);
    add(1'b0, 4'b1001, P, 1, 4'b0000, 8'h3C);
    add(1'b0, 4'b1001, P, 1, 4'b0001, 8'h00);
    add(1'b0, 4'b1001, P, 2, 4'b0001, 8'hA5);
    // owner drops on the edge its timer reaches zero, nobody else waiting
    add(1'b1, 4'b0000, P, 1, 4'b0000, 8'h00);
    add(1'b0, 4'b0010, P, 1, 4'b0010, 8'h00);
    add(1'b0, 4'b0010, P, 6, 4'b0010, 8'h5A);
    add(1'b0, 4'b0000, P, 1, 4'b0000, 8'h5A);
    add(1'b0, 4'b0000, P, 2, 4'b0000, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        rst = vecs[i].rst;
        req = vecs[i].req;
        pattern = vecs[i].pat;
        @(posedge clk50);
        #1;
        cmp("vec", i, c, vecs[i].g, vecs[i].l);
      end
    end

    // idle LEDs after reset: heartbeat blink, or steady zero
    rst = 1'b1;
    req = 4'b0000;
    pattern = P;
    @(posedge clk50);
    #1;
    cmp("hb_rst", 0, 0, 4'b0000, 8'h00);
    rst = 1'b0;
    for (int k = 1; k <= 4 * DW; k++) begin
      @(posedge clk50);
      #1;
`ifdef LED_ARB_HEARTBEAT_EN
      hb_exp = ((((k - 1) / DW) % 2) == 1) ? 8'h80 : 8'h00;
`else
      hb_exp = 8'h00;
`endif
      cmp("idle_leds", 0, k, 4'b0000, hb_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_share_arb.md
# led_share_arb

Round-robin arbiter sharing the board's 8-LED bank among four pattern sources: the free-running counter display and up to three debug/status sources. Each requester owns the LEDs for a minimum dwell period before a waiting requester is granted, with one blanking cycle between owners. Sits between the pattern generators and the `LEDS` pins, clocked from the `clkgen` output domain.

## Interface

- `DWELL_CYCLES`, default 25000000: minimum ownership time in cycles when another requester is waiting (0.5 s at 50 MHz); legal range 1 to 2^`TW`.
- `TW`, default 25: dwell timer width.

- `clk50`  in  1: clock, all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  4: level request per source; bit i belongs to source i.
- `pattern`  in  32: source data; source i drives bits [8i+7:8i].
- `grant`  out  4: registered one-hot grant; all zero when there is no owner.
- `LEDS`  out  8: registered LED drive.

## Operation

- State machine has three states: IDLE, GRANT and SWITCH. Reset state is IDLE.
- Round-robin pointer `last` (2 bits) resets to 3, so source 0 has highest priority after reset.
- Arbitration scans `req` starting at index (`last`+1) mod 4 and wraps. The first set bit wins.
- IDLE:
  - `grant`=0.
  - If any `req` bit is set: grant the winner, set `last` to the winner, load the timer with `DWELL_CYCLES`-1, go to GRANT.
- GRANT:
  - The timer decrements each cycle and saturates at 0.
  - If `req[owner]`=0: go to SWITCH. This takes precedence over everything else.
  - Else if timer=0 and any other `req` bit is set: go to SWITCH.
  - Else if timer=0 and no other request is pending: reload the timer and stay in GRANT (the owner keeps the LEDs).
- SWITCH:
  - `grant`=0 for exactly one cycle.
  - Then arbitrate as in IDLE: go to GRANT if any request is present, otherwise go to IDLE.
  - The previous owner is eligible only if it is still the sole requester, or wins by pointer order.
- `LEDS` update: each cycle `LEDS` <= `pattern` slice of the current `grant` owner. When `grant`=0, `LEDS` takes the idle value (see Configuration).
- Timer width: `TW` bits, unsigned; there is no wrap below 0.
- `pattern` is not latched. Pattern changes during ownership propagate with the fixed `LEDS` latency.

## Timing

- Reset values: `grant`=4'b0000, `LEDS`=8'h00, `last`=3, timer=0, state IDLE. These apply on the first edge with `rst`=1, including mid-grant.
- Request to grant: `req` sampled high at edge t in IDLE gives `grant` high after edge t.
- Grant to display: `LEDS` shows the owner's slice from the following edge, i.e. one cycle after `grant`.
- Ownership with contention lasts exactly `DWELL_CYCLES` cycles of `grant` high, followed by 1 blank cycle, then the next owner.
- Owner drops `req` at edge t: `grant` falls after edge t, and `LEDS` blanks one cycle later.
- Owner drops `req` on the same edge the timer reaches 0: one SWITCH, same as any drop.
- All four sources requesting continuously: grant order 0,1,2,3,0,..., each for `DWELL_CYCLES` cycles, separated by a single zero-grant cycle.
- With `DWELL_CYCLES`=1: alternating owners every 2 cycles (1 granted + 1 blank).

## Configuration

- `LED_ARB_HEARTBEAT_EN` defined:
  - A free-running heartbeat counter toggles a bit every `DWELL_CYCLES` cycles while `grant`=0 (IDLE and SWITCH).
  - `LEDS`=8'h80 when the bit is 1, and 8'h00 when it is 0.
  - The heartbeat counter and bit reset to 0 on `rst` and hold their value while a grant is active.
- `LED_ARB_HEARTBEAT_EN` undefined: the idle value is always 8'h00, and no heartbeat logic is synthesized.

## Test plan

All scenarios use `DWELL_CYCLES`=8.

- Reset then `req`=0001, `pattern[7:0]`=8'hA5:
  - `grant`=0001 one cycle after `req`.
  - `LEDS`=8'hA5 one cycle later.
  - Ownership holds indefinitely with periodic timer reload.
- `req`=1111 held for 40 cycles:
  - Grants go 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
  - Each nonzero grant lasts exactly 8 cycles.
- Source 2 owns, then `req[2]` drops at cycle 3 of the dwell while `req[0]` is high:
  - `grant`=0000 for 1 cycle, then `grant`=0001 with no dwell wait.
  - `LEDS` goes to 8'h00, then to source 0's pattern.
- `rst` asserted mid-grant of source 1 with `req`=1111:
  - Next cycle `grant`=0, `LEDS`=0.
  - After `rst` deasserts, source 0 is granted first.
- Pointer wrap:
  - Source 3 owns, then `req` becomes 1001 at expiry.
  - Next owner is source 0, not source 3.
- `LED_ARB_HEARTBEAT_EN` defined, `req`=0:
  - `LEDS` alternates 8'h00 and 8'h80 every 8 cycles.
  - With the macro undefined, `LEDS` stays 8'h00.
